led_pattern_sequencer: RTL and testbench
========================================

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clock cycles per pattern tick (1 s at 50 MHz); legal range 2..2^32-1.
REQ-002 SHALL have parameter AUTO_TICKS, default 8, ticks spent in one mode before auto-advance (used only with LED_SEQ_AUTO_EN); legal range 1..255.
REQ-003 SHALL have port clock_50  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_next_n  input  1  raw pushbutton, active-low, asynchronous to clock_50.
REQ-006 SHALL have port pause  input  1  level; high freezes prescaler and pattern.
REQ-007 SHALL have port LEDG  output  8  green LEDs, active-high, driven directly from the pattern register.
REQ-008 SHALL have port mode  output  2  current mode: 0=BLINK, 1=CHASE, 2=BOUNCE, 3=FILL.
REQ-009 SHALL have port tick  output  1  one-cycle pulse at each prescaler wrap.

Function
REQ-010 SHALL use a 32-bit prescaler that counts 0..TICK_DIV-1, asserts tick in the cycle it equals TICK_DIV-1, and wraps to 0 on the next edge.
REQ-011 SHALL hold the prescaler and keep tick at 0 while pause=1.
REQ-012 SHALL pass key_next_n through a 2-flop synchronizer followed by falling-edge detect, giving a one-cycle next_evt; mode SHALL change on the 3rd rising edge after key_next_n is first sampled low; holding the key SHALL give exactly one event.
REQ-013 SHALL advance mode on next_evt: BLINK->CHASE->BOUNCE->FILL->BLINK, wrapping from 3 to 0.
REQ-014 SHALL, on every mode change, load the entry pattern of the new mode, clear the prescaler to 0, and set the bounce direction to left, all in the same cycle.
REQ-015 SHALL use entry patterns BLINK 8'h00, CHASE 8'h01, BOUNCE 8'h01, FILL 8'h00.
REQ-016 BLINK SHALL update on tick as pat <= ~pat.
REQ-017 CHASE SHALL update on tick as a left rotate, with 8'h80 going to 8'h01.
REQ-018 BOUNCE SHALL shift one position per tick in the current direction, reverse to right when the result is 8'h80, reverse to left when the result is 8'h01, and never hold an end value for two ticks.
REQ-019 FILL SHALL update on tick as pat <= {pat[6:0],1'b1}, with 8'hFF going to 8'h00.
REQ-020 SHALL give next_evt priority over tick in the same cycle: the mode changes, the entry pattern loads, and the tick update is discarded.
REQ-021 SHALL still act on next_evt while pause=1 (mode advances, entry pattern loads) while the prescaler stays held at 0.
REQ-022 SHALL make LEDG and mode pure register outputs with no combinational path from inputs.

Reset
REQ-023 SHALL, on reset_n=0 and independent of the clock, set mode=BLINK, LEDG=8'h00, prescaler=0, tick=0, direction=left, synchronizer flops=1, and auto counter=0.
REQ-024 SHALL treat reset mid-pattern as a full restart; the first tick after release SHALL occur TICK_DIV cycles after the first clock edge with reset_n=1.

Configuration
REQ-025 SHALL honour macro LED_SEQ_AUTO_EN: when defined, an 8-bit counter counts ticks in the current mode, and the AUTO_TICKS-th tick advances mode exactly like next_evt instead of updating the pattern; the counter clears on any mode change.
REQ-026 SHALL, without LED_SEQ_AUTO_EN, contain no auto counter, change mode only on next_evt, and ignore AUTO_TICKS.

Structure
REQ-027 SHALL take from shared package led_seq_pkg the 2-bit mode enum typedef and the four entry-pattern constants.
REQ-028 SHALL implement the prescaler as sub-module led_tick_gen (inputs clock_50, reset_n, clear, hold; output tick; parameter TICK_DIV).

Verification (TICK_DIV=4, AUTO_TICKS=3)
REQ-029 Reset release, no key -> LEDG 00, FF, 00, FF on ticks 0..3; tick every 4 cycles.
REQ-030 One key press -> mode=1 three edges after the low sample; LEDG 01, 02, 04 ... 80, 01 across ticks; key held 100 cycles gives no further advance.
REQ-031 Two presses (BOUNCE) -> LEDG 01, 02 ... 80, 40 ... 01, 02 with no duplicated end values.
REQ-032 pause=1 for 20 cycles mid-FILL at 8'h07 -> LEDG stays 07, tick=0; after release 0F, then 1F ... FF, 00.
REQ-033 next_evt in the same cycle as tick, and reset_n pulsed low mid-CHASE -> the entry pattern wins; reset gives LEDG=00 and mode=0 immediately.
REQ-034 LED_SEQ_AUTO_EN defined, no key -> mode steps 0,1,2,3,0 every 3 ticks; without the macro, mode stays 0 for 50 ticks.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: mode encoding and the
// pattern each mode starts from when it is entered.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    localparam logic [7:0] PAT_BLINK  = 8'h00;
    localparam logic [7:0] PAT_CHASE  = 8'h01;
    localparam logic [7:0] PAT_BOUNCE = 8'h01;
    localparam logic [7:0] PAT_FILL   = 8'h00;

    function automatic logic [7:0] entry_pat(input mode_e m);
        case (m)
            MODE_BLINK:  return PAT_BLINK;
            MODE_CHASE:  return PAT_CHASE;
            MODE_BOUNCE: return PAT_BOUNCE;
            default:     return PAT_FILL;
        endcase
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern-rate prescaler: counts 0..TICK_DIV-1 and pulses tick on the last
// count. clear forces the count to 0 and beats hold.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clock_50,
    input  logic reset_n,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

    logic [31:0] cnt;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 32'd1;
        end
    end

    assign tick = !hold && (cnt == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Four-mode LED pattern sequencer stepped by a prescaler tick; a pushbutton
// cycles the mode. Define LED_SEQ_AUTO_EN to also auto-advance every AUTO_TICKS ticks.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned AUTO_TICKS = 8
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       key_next_n,
    input  logic       pause,
    output logic [7:0] LEDG,
    output logic [1:0] mode,
    output logic       tick
);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end
    if (AUTO_TICKS < 1 || AUTO_TICKS > 255) begin : g_bad_auto_ticks
        $error("AUTO_TICKS must be in 1..255");
    end

    logic       key_s1, key_s2, key_s3;
    logic       next_evt;
    logic       auto_adv;
    logic       advance;
    mode_e      mode_q;
    logic [7:0] pat_q, pat_nxt;
    logic       dir_right, dir_nxt;

    // Key idles high, so the synchronizer resets high to avoid a phantom press.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_s3 <= 1'b1;
        end else begin
            key_s1 <= key_next_n;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
        end
    end

    assign next_evt = key_s3 & ~key_s2;

`ifdef LED_SEQ_AUTO_EN
    logic [7:0] auto_cnt;

    assign auto_adv = tick && (auto_cnt == 8'(AUTO_TICKS - 1));

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt <= '0;
        end else if (next_evt || auto_adv) begin
            auto_cnt <= '0;
        end else if (tick) begin
            auto_cnt <= auto_cnt + 8'd1;
        end
    end
`else
    assign auto_adv = 1'b0;
`endif

    assign advance = next_evt | auto_adv;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .clear    (advance),
        .hold     (pause),
        .tick     (tick)
    );

    always_comb begin
        pat_nxt = pat_q;
        dir_nxt = dir_right;
        case (mode_q)
            MODE_BLINK: pat_nxt = ~pat_q;
            MODE_CHASE: pat_nxt = {pat_q[6:0], pat_q[7]};
            MODE_BOUNCE: begin
                // Turn around on arriving at an end so no end value is shown twice.
                if (dir_right) begin
                    pat_nxt = pat_q >> 1;
                    if (pat_nxt == 8'h01) dir_nxt = 1'b0;
                end else begin
                    pat_nxt = pat_q << 1;
                    if (pat_nxt == 8'h80) dir_nxt = 1'b1;
                end
            end
            default: pat_nxt = (pat_q == 8'hFF) ? 8'h00 : {pat_q[6:0], 1'b1};
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_BLINK;
            pat_q     <= PAT_BLINK;
            dir_right <= 1'b0;
        end else if (advance) begin
            mode_q    <= next_mode(mode_q);
            pat_q     <= entry_pat(next_mode(mode_q));
            dir_right <= 1'b0;
        end else if (tick) begin
            pat_q     <= pat_nxt;
            dir_right <= dir_nxt;
        end
    end

    assign LEDG = pat_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (TICK_DIV=4, AUTO_TICKS=3):
// table vectors, directed corner sequences and a randomized run against a pattern model.
module tb_led_pattern_sequencer;

    localparam int TD = 4;
    localparam int AT = 3;

    logic       clock_50   = 1'b0;
    logic       reset_n    = 1'b0;
    logic       key_next_n = 1'b1;
    logic       pause      = 1'b0;
    logic [7:0] LEDG;
    logic [1:0] mode;
    logic       tick;

    int n_cmp  = 0;
    int n_fail = 0;

    led_pattern_sequencer #(.TICK_DIV(TD), .AUTO_TICKS(AT)) dut (
        .clock_50   (clock_50),
        .reset_n    (reset_n),
        .key_next_n (key_next_n),
        .pause      (pause),
        .LEDG       (LEDG),
        .mode       (mode),
        .tick       (tick)
    );

    always #5 clock_50 = ~clock_50;

    // Reference model: mode plus number of pattern steps taken since entering it.
    int     m_mode, m_n, m_phase, m_tim;
    bit     m_prev_key;
    longint m_edge;
    longint m_pend[$];

    function automatic logic [7:0] pat_of(input int md, input int n);
        int k;
        case (md)
            0: return (n % 2) ? 8'hFF : 8'h00;
            1: return 8'(1 << (n % 8));
            2: begin
                k = n % 14;
                return 8'(1 << ((k <= 7) ? k : 14 - k));
            end
            default: begin
                k = n % 9;
                return 8'((1 << k) - 1);
            end
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_phase = 0; m_tim = 0;
        m_prev_key = 1'b1;
        m_edge = 0;
        m_pend.delete();
    endtask

    task automatic model_step(input bit key, input bit pz);
        bit evt, tk, adv;
        m_edge++;
        evt = 1'b0;
        if (m_pend.size() > 0 && m_pend[0] == m_edge) begin
            evt = 1'b1;
            void'(m_pend.pop_front());
        end
        // A press first sampled low on this edge changes mode two edges later.
        if (!key && m_prev_key) m_pend.push_back(m_edge + 2);
        m_prev_key = key;
        tk  = (m_phase == TD - 1) && !pz;
        adv = evt;
`ifdef LED_SEQ_AUTO_EN
        if (tk && m_tim == AT - 1) adv = 1'b1;
`endif
        if (adv) begin
            m_mode = (m_mode + 1) % 4;
            m_n = 0; m_phase = 0; m_tim = 0;
        end else begin
            if (tk) begin
                m_n++;
                m_tim++;
            end
            if (!pz) m_phase = (m_phase + 1) % TD;
        end
    endtask

    task automatic step();
        @(posedge clock_50);
        model_step(key_next_n, pause);
        @(negedge clock_50);
        chk("model_led", LEDG, pat_of(m_mode, m_n));
        chk("model_mode", mode, m_mode);
        chk("model_tick", tick, int'((m_phase == TD - 1) && !pause));
    endtask

    task automatic run_to_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * TD && !seen; i++) begin
            step();
            seen = tick;
        end
        chk("tick_wait", int'(seen), 1);
        step();
    endtask

    task automatic press();
        key_next_n = 1'b0;
        step(); step(); step();
        key_next_n = 1'b1;
        step();
    endtask

    // Called at a falling edge; reset is asserted between clock edges.
    task automatic do_reset();
        key_next_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_led", LEDG, 8'h00);
        chk("rst_mode", mode, 0);
        chk("rst_tick", tick, 0);
        @(posedge clock_50);
        @(negedge clock_50);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         pz;
        bit         key;
        logic [7:0] led;
        logic [1:0] md;
        bit         tk;
    } vec_t;

    vec_t       tbl[18];
    logic [7:0] chase_exp[8];
    logic [7:0] bounce_exp[15];
    logic [7:0] fill_exp[6];

    initial begin
        int hold_left;
        int n_auto;

        tbl[0]  = '{0, 1, 8'h00, 0, 0};
        tbl[1]  = '{0, 1, 8'h00, 0, 0};
        tbl[2]  = '{0, 1, 8'h00, 0, 1};
        tbl[3]  = '{0, 1, 8'hFF, 0, 0};
        tbl[4]  = '{0, 1, 8'hFF, 0, 0};
        tbl[5]  = '{0, 1, 8'hFF, 0, 0};
        tbl[6]  = '{0, 1, 8'hFF, 0, 1};
        tbl[7]  = '{0, 1, 8'h00, 0, 0};
        tbl[8]  = '{1, 1, 8'h00, 0, 0};
        tbl[9]  = '{1, 1, 8'h00, 0, 0};
        tbl[10] = '{0, 1, 8'h00, 0, 0};
        tbl[11] = '{0, 1, 8'h00, 0, 0};
        tbl[12] = '{0, 1, 8'h00, 0, 1};
        tbl[13] = '{0, 1, 8'hFF, 0, 0};
        tbl[14] = '{0, 0, 8'hFF, 0, 0};
        tbl[15] = '{0, 0, 8'hFF, 0, 0};
        tbl[16] = '{0, 0, 8'h01, 1, 0};
        tbl[17] = '{0, 1, 8'h01, 1, 0};
        chase_exp  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                       8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        fill_exp   = '{8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

        model_reset();
        @(negedge clock_50);
        chk("por_led", LEDG, 8'h00);
        chk("por_mode", mode, 0);
        chk("por_tick", tick, 0);
        @(negedge clock_50);
        reset_n = 1'b1;

`ifndef LED_SEQ_AUTO_EN
        for (int i = 0; i < 18; i++) begin
            pause      = tbl[i].pz;
            key_next_n = tbl[i].key;
            step();
            chk("tbl_led", LEDG, tbl[i].led);
            chk("tbl_mode", mode, tbl[i].md);
            chk("tbl_tick", tick, tbl[i].tk);
        end
        pause = 1'b0; key_next_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_to_tick();
            chk("chase_led", LEDG, chase_exp[i]);
        end

        // Key held low for 100 cycles must produce exactly one advance.
        key_next_n = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("held_mode", mode, 2);
        key_next_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) press();
        chk("bounce_entry_mode", mode, 2);
        chk("bounce_entry_led", LEDG, 8'h01);
        for (int i = 0; i < 15; i++) begin
            run_to_tick();
            chk("bounce_led", LEDG, bounce_exp[i]);
        end

        press();
        chk("fill_entry_led", LEDG, 8'h00);
        chk("fill_entry_mode", mode, 3);
        for (int i = 0; i < 3; i++) run_to_tick();
        chk("fill_07", LEDG, 8'h07);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("pause_led", LEDG, 8'h07);
            chk("pause_tick", tick, 0);
        end
        pause = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_to_tick();
            chk("fill_led", LEDG, fill_exp[i]);
        end

        // Line the key event up with a prescaler wrap: the entry pattern must win.
        press();
        chk("coll_pre_mode", mode, 0);
        key_next_n = 1'b0;
        step();
        step();
        chk("coll_tick", tick, 1);
        step();
        key_next_n = 1'b1;
        chk("coll_mode", mode, 1);
        chk("coll_led", LEDG, 8'h01);

        for (int i = 0; i < 6; i++) step();
        chk("mid_chase_led", LEDG, 8'h02);
        do_reset();
        step(); chk("rel_tick1", tick, 0);
        step(); chk("rel_tick2", tick, 0);
        step(); chk("rel_tick3", tick, 1);
        step(); chk("rel_led", LEDG, 8'hFF);

        // Key events still act while paused; prescaler stays at 0.
        pause = 1'b1;
        press();
        chk("pz_evt_mode", mode, 1);
        chk("pz_evt_led", LEDG, 8'h01);
        chk("pz_evt_tick", tick, 0);
        for (int i = 0; i < 6; i++) step();
        chk("pz_hold_led", LEDG, 8'h01);
        pause = 1'b0;
        step();
`endif

`ifdef LED_SEQ_AUTO_EN
        n_auto = 15;
`else
        n_auto = 50;
`endif
        do_reset();
        for (int k = 1; k <= n_auto; k++) begin
            run_to_tick();
`ifdef LED_SEQ_AUTO_EN
            chk("auto_mode", mode, (k / AT) % 4);
`else
            chk("auto_mode", mode, 0);
`endif
        end

        hold_left = 1;
        for (int c = 0; c < 3000; c++) begin
            hold_left--;
            if (hold_left == 0) begin
                key_next_n = ~key_next_n;
                hold_left  = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 99) < 4) pause = ~pause;
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
